hps_image_loader: RTL and testbench

HPS_IMAGE_LOADER -- requirements
Module: hps_image_loader

---
 rtl/hps_image_loader_pkg.sv | 40 ++++
 rtl/hps_image_loader_if.sv | 27 ++
 rtl/hps_image_loader_sync_2ff.sv | 29 ++
 rtl/hps_image_loader.sv | 174 +++++++++++++++++
 tb/tb_hps_image_loader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hps_image_loader_pkg.sv
// Shared image/video constants, loader state encoding and the memory-write payload.
package hps_image_loader_pkg;

  localparam int unsigned IMG_W_DEF        = 160;
  localparam int unsigned IMG_H_DEF        = 120;
  localparam int unsigned FRAME_PIX        = IMG_W_DEF * IMG_H_DEF;
  localparam int unsigned PIX_PER_WORD_DEF = 4;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned STATE_W = 3;

  // Video pipeline: 640x480 VGA scan, each source pixel replicated 4x4
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_SCALE    = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_REQ = 3'd1;
  localparam logic [STATE_W-1:0] ST_WRITE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACK      = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

  typedef struct packed {
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } mem_wr_t;

  // Byte i of a packed HPS word, byte 0 in bits 7:0
  function automatic logic [PIX_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] sh;
    sh = w >> {i, 3'b000};
    return sh[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/hps_image_loader_if.sv
// HPS handshake plus image-memory write port of the frame loader.
interface hps_image_loader_if;
  import hps_image_loader_pkg::*;

  logic              hps_start;
  logic              hps_req;
  logic [WORD_W-1:0] hps_data;
  logic              hps_ack;
  logic [ADDR_W-1:0] mem_wraddr;
  logic [PIX_W-1:0]  mem_wrdata;
  logic              mem_wren;
  logic              busy;
  logic              load_done;
  logic              overflow;

  // HPS side: drives the request/data, observes everything else
  modport master (
    output hps_start, hps_req, hps_data,
    input  hps_ack, mem_wraddr, mem_wrdata, mem_wren, busy, load_done, overflow
  );

  // Loader side
  modport slave (
    input  hps_start, hps_req, hps_data,
    output hps_ack, mem_wraddr, mem_wrdata, mem_wren, busy, load_done, overflow
  );
endinterface

// File: rtl/hps_image_loader_sync_2ff.sv
// 1-bit double-flop synchroniser for signals crossing into the pixel clock.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next values: shift the input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/hps_image_loader.sv
// Loads a frame of packed HPS pixel words into image memory via a 4-phase handshake.
module hps_image_loader
  import hps_image_loader_pkg::*;
#(
  parameter int unsigned IMG_W        = IMG_W_DEF,
  parameter int unsigned IMG_H        = IMG_H_DEF,
  parameter int unsigned PIX_PER_WORD = PIX_PER_WORD_DEF
) (
  input logic               clk_50MHz,
  input logic               vga_reset,
  hps_image_loader_if.slave bus
);
  localparam int unsigned       PIX_TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] PTR_MAX   = ADDR_W'(PIX_TOTAL);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PIX_PER_WORD - 1);

  logic req_s, start_s;

  logic [STATE_W-1:0] state_d, state_q;
  logic [ADDR_W-1:0]  ptr_d, ptr_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [WORD_W-1:0]  word_d, word_q;
  logic               pend_d, pend_q;
  logic               start_prev_d, start_prev_q;
  logic               ovf_d, ovf_q;
  logic               ack_d, ack_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  mem_wr_t            wr_d, wr_q;

  logic               start_rise_c, capture_c, emit_c;
  logic [PIX_W-1:0]   emit_byte_c;

  sync_2ff u_sync_req (
    .clk   (clk_50MHz),
    .rst_n (vga_reset),
    .d     (bus.hps_req),
    .q     (req_s)
  );

  sync_2ff u_sync_start (
    .clk   (clk_50MHz),
    .rst_n (vga_reset),
    .d     (bus.hps_start),
    .q     (start_s)
  );

  // Next-state and next-output logic; outputs are registered from these _d values
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    word_d       = word_q;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    ack_d        = ack_q;
    start_prev_d = start_s;
    wr_d         = wr_q;
    wr_d.wren    = 1'b0;
    start_rise_c = start_s & ~start_prev_q;
    capture_c    = 1'b0;
    emit_c       = 1'b0;
    emit_byte_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise_c) begin
          ptr_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ, ST_DONE: begin
        if (start_rise_c) begin
          ptr_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_WAIT_REQ;
        end else if (req_s) begin
          capture_c = 1'b1;
        end
      end
      ST_WRITE: begin
        if (start_rise_c) pend_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
          emit_c      = 1'b1;
          emit_byte_c = word_byte(word_q, idx_d);
        end
      end
      ST_ACK: begin
        if (start_rise_c) pend_d = 1'b1;
        if (!req_s) begin
          ack_d = 1'b0;
          if (pend_d) begin
            pend_d  = 1'b0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_WAIT_REQ;
          end else if (ptr_q == PTR_MAX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A captured word starts streaming with its byte 0 on the next cycle
    if (capture_c) begin
      word_d      = bus.hps_data;
      idx_d       = '0;
      emit_c      = 1'b1;
      emit_byte_c = word_byte(bus.hps_data, '0);
      state_d     = ST_WRITE;
    end

    // Pointer saturates at the frame size; bytes past it are dropped and flagged
    if (emit_c) begin
      if (ptr_q < PTR_MAX) begin
        wr_d.wren = 1'b1;
        wr_d.addr = ptr_q;
        wr_d.data = emit_byte_c;
        ptr_d     = ptr_q + ADDR_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      start_prev_q <= 1'b0;
      ovf_q        <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_q         <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      start_prev_q <= start_prev_d;
      ovf_q        <= ovf_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_q         <= wr_d;
    end
  end

  assign bus.hps_ack    = ack_q;
  assign bus.mem_wren   = wr_q.wren;
  assign bus.mem_wraddr = wr_q.addr;
  assign bus.mem_wrdata = wr_q.data;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_hps_image_loader.sv
// Directed self-checking bench for the HPS frame loader.
module tb_hps_image_loader;

  logic clk_50MHz = 1'b0;
  logic vga_reset;

  hps_image_loader_if bus ();

  hps_image_loader dut (
    .clk_50MHz (clk_50MHz),
    .vga_reset (vga_reset),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int total = 0;
  int bad   = 0;
  int tmo   = 0;

  // Write-port observer
  int          wr_count  = 0;
  int          order_err = 0;
  logic [14:0] prev_addr = 15'h7FFF;
  logic [14:0] last_addr = '0;
  logic [7:0]  last_data = '0;

  always @(posedge clk_50MHz) begin
    if (bus.mem_wren === 1'b1) begin
      wr_count <= wr_count + 1;
      if (bus.mem_wraddr != 15'(prev_addr + 15'd1) && bus.mem_wraddr != 15'd0)
        order_err <= order_err + 1;
      prev_addr <= bus.mem_wraddr;
      last_addr <= bus.mem_wraddr;
      last_data <= bus.mem_wrdata;
    end
  end

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (bus.hps_ack !== v && n < 40) begin
      step();
      n++;
    end
    if (bus.hps_ack !== v) tmo++;
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.hps_data = w;
    bus.hps_req  = 1'b1;
    wait_ack(1'b1);
    bus.hps_req  = 1'b0;
    wait_ack(1'b0);
  endtask

  function automatic logic [31:0] outs_vec();
    return {bus.hps_ack, bus.mem_wren, bus.busy, bus.load_done, bus.overflow,
            bus.mem_wraddr, bus.mem_wrdata};
  endfunction

  int snap;

  initial begin
    vga_reset     = 1'b0;
    bus.hps_start = 1'b0;
    bus.hps_req   = 1'b0;
    bus.hps_data  = '0;
    steps(3);

    // Reset state
    chk("reset_outputs", outs_vec(), 32'h0);

    // No activity after reset release without a start edge, even with req high
    vga_reset   = 1'b1;
    bus.hps_req = 1'b1;
    steps(10);
    chk("idle_no_ack", {31'd0, bus.hps_ack}, 32'd0);
    chk("idle_no_writes", wr_count, 0);
    chk("idle_not_busy", {31'd0, bus.busy}, 32'd0);
    bus.hps_req = 1'b0;
    steps(3);

    // Start a frame
    bus.hps_start = 1'b1;
    steps(4);
    chk("start_busy", {31'd0, bus.busy}, 32'd1);
    bus.hps_start = 1'b0;
    steps(3);

    // One word: byte order, write latency and ack timing
    bus.hps_data = 32'h44332211;
    bus.hps_req  = 1'b1;
    steps(2);
    chk("w0_pre_wren", {31'd0, bus.mem_wren}, 32'd0);
    step();
    chk("w0_b0", {16'd0, bus.mem_wren, bus.mem_wraddr, bus.mem_wrdata}, {16'd0, 1'b1, 15'd0, 8'h11});
    step();
    chk("w0_b1", {16'd0, bus.mem_wren, bus.mem_wraddr, bus.mem_wrdata}, {16'd0, 1'b1, 15'd1, 8'h22});
    step();
    chk("w0_b2", {16'd0, bus.mem_wren, bus.mem_wraddr, bus.mem_wrdata}, {16'd0, 1'b1, 15'd2, 8'h33});
    step();
    chk("w0_b3", {16'd0, bus.mem_wren, bus.mem_wraddr, bus.mem_wrdata}, {16'd0, 1'b1, 15'd3, 8'h44});
    chk("w0_ack_not_yet", {31'd0, bus.hps_ack}, 32'd0);
    step();
    chk("w0_ack_wren", {30'd0, bus.hps_ack, bus.mem_wren}, {30'd0, 1'b1, 1'b0});
    bus.hps_req = 1'b0;
    steps(2);
    chk("w0_ack_hold", {31'd0, bus.hps_ack}, 32'd1);
    step();
    chk("w0_ack_drop", {31'd0, bus.hps_ack}, 32'd0);
    chk("w0_count", wr_count, 4);

    // Reset in the middle of streaming a word
    snap = wr_count;
    bus.hps_data = 32'h88776655;
    bus.hps_req  = 1'b1;
    steps(5);
    chk("mid_pre_addr", {17'd0, last_addr}, {17'd0, 15'd5});
    vga_reset   = 1'b0;
    bus.hps_req = 1'b0;
    #1;
    chk("mid_reset_outputs", outs_vec(), 32'h0);
    steps(6);
    chk("mid_reset_writes", wr_count - snap, 2);
    chk("mid_reset_quiet", outs_vec(), 32'h0);
    vga_reset = 1'b1;
    steps(3);

    // Full frame of 4800 words
    bus.hps_start = 1'b1;
    steps(4);
    bus.hps_start = 1'b0;
    snap = wr_count;
    for (int i = 0; i < 4800; i++) begin
      send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    end
    step();
    chk("frame_writes", wr_count - snap, 19200);
    chk("frame_last_addr", {17'd0, last_addr}, 32'd19199);
    chk("frame_last_data", {24'd0, last_data}, 32'h000000FF);
    chk("frame_order", order_err, 0);
    chk("frame_flags", {29'd0, bus.load_done, bus.busy, bus.overflow}, {29'd0, 3'b100});
    chk("frame_timeouts", tmo, 0);

    // Word past a full frame: handshaked, discarded, flagged
    snap = wr_count;
    send_word(32'hCAFEF00D);
    step();
    chk("extra_writes", wr_count - snap, 0);
    chk("extra_flags", {29'd0, bus.load_done, bus.busy, bus.overflow}, {29'd0, 3'b101});
    chk("extra_timeouts", tmo, 0);

    // Restart pulsed during the ack of word 10
    bus.hps_start = 1'b1;
    steps(4);
    bus.hps_start = 1'b0;
    steps(3);
    chk("restart_ovf_clear", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 10; i++) send_word(32'h01010101 * 32'(i));
    snap = wr_count;
    bus.hps_data = 32'h0B0A0908;
    bus.hps_req  = 1'b1;
    wait_ack(1'b1);
    bus.hps_start = 1'b1;
    steps(6);
    chk("pend_ack_held", {31'd0, bus.hps_ack}, 32'd1);
    chk("pend_w10_addr", {17'd0, last_addr}, 32'd43);
    bus.hps_req = 1'b0;
    wait_ack(1'b0);
    bus.hps_start = 1'b0;
    chk("pend_busy", {30'd0, bus.busy, bus.load_done}, {30'd0, 2'b10});
    chk("pend_w10_writes", wr_count - snap, 4);
    snap = wr_count;
    send_word(32'hDDCCBBAA);
    step();
    chk("pend_next_writes", wr_count - snap, 4);
    chk("pend_next_addr", {17'd0, last_addr}, 32'd3);
    chk("pend_next_data", {24'd0, last_data}, 32'h000000DD);

    // Request held high for 20 cycles: a single capture only
    snap = wr_count;
    bus.hps_data = 32'h87654321;
    bus.hps_req  = 1'b1;
    steps(20);
    chk("hold_ack", {31'd0, bus.hps_ack}, 32'd1);
    chk("hold_writes", wr_count - snap, 4);
    chk("hold_last", {9'd0, last_addr, last_data}, {9'd0, 15'd7, 8'h87});
    bus.hps_req = 1'b0;
    wait_ack(1'b0);
    steps(5);
    chk("hold_no_recapture", wr_count - snap, 4);
    chk("final_timeouts", tmo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
